conv2_window_ctrl: RTL and testbench
====================================

Name: conv2_window_ctrl

Overview:
- Sequencer for the conv-layer-2 sliding-window line buffer: 14x14 feature map, 3x3 kernel, 31-entry shift buffer.
- Accepts one raster-ordered frame of pixels through a valid/ready handshake and drives the buffer shift-enable.
- Tracks the row and column of each pixel and marks each cycle where the nine buffer taps form a legal 3x3 window.
- Holds the buffer frozen while the downstream MAC stalls.
- Sits between the pooling-1 output stream and the buffer/conv-2 MAC array.

Parameters:
FEATURE_MAP_SIZE  14  pixels per row and rows per frame (N)
KERNEL_SIZE  3  window edge (K); buffer depth is (K-1)*N+K
CNT_W  4  width of the row/column counters; must satisfy 2^CNT_W >= N

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
abort  in  1  synchronous; forces return to IDLE on the next edge
in_valid  in  1  upstream pixel valid
in_ready  out  1  controller can accept a pixel this cycle
buf_en  out  1  shift-enable to the line buffer; equals in_valid & in_ready (combinational)
win_valid  out  1  buffer taps hold a complete 3x3 window
win_ready  in  1  downstream consumes the window this cycle
win_row  out  CNT_W  top-left output row of the current window (0..N-K)
win_col  out  CNT_W  top-left output column of the current window (0..N-K)
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse after the last window is consumed

Behaviour:
- Reset values: state=IDLE, row/col counters=0, in_ready=0, win_valid=0, win_row=0, win_col=0, busy=0, frame_done=0.
- The controller never resets buffer contents. Windows are flagged only after K-1 full rows plus K pixels of the current frame have been shifted in, so stale data from a previous frame is never exposed.
- States:
  - IDLE: in_ready=0. start -> RUN, with row=col=0.
  - RUN: in_ready = ~win_valid | win_ready. A pixel is accepted on a cycle where in_valid & in_ready is high.
  - DRAIN: entered on acceptance of pixel (N-1,N-1). in_ready=0. Stays until win_valid is low, or is high with win_ready high, then -> DONE.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Pixel counting:
  - On acceptance, col increments.
  - At col=N-1, col wraps to 0 and row increments.
- Window flag, registered with one cycle of latency after acceptance:
  - If an accepted pixel (r,c) has r>=K-1 and c>=K-1, then next cycle win_valid=1, win_row=r-(K-1), win_col=c-(K-1).
  - Columns 0..K-2 of each row never produce a window, which suppresses row-wrap windows.
- Window retirement:
  - win_valid clears on a win_ready cycle unless a new window-producing pixel is accepted in the same cycle. In that case win_valid stays 1 and win_row/win_col update.
  - While win_valid=1 and win_ready=0: in_ready=0 and buf_en=0, so buffer taps and win_row/win_col hold stable.
- Frame totals: exactly (N-K+1)^2 = 144 windows and N*N = 196 accepted pixels per frame.
- Simultaneous and edge cases:
  - abort has priority over every other event. It clears win_valid and the counters with no frame_done pulse.
  - start while busy is ignored.
  - start in the same cycle as the DONE pulse is ignored; IDLE is reached first.
  - in_valid in IDLE, DRAIN or DONE is not accepted (in_ready=0).
- Asynchronous reset mid-frame returns all outputs to reset values immediately. The next frame requires a new start.

Test Plan:
1. Reset, then start, then 196 pixels with in_valid held high and win_ready tied high -> first win_valid on the cycle after pixel 31 (r=2,c=2) with win_row=0, win_col=0; 144 windows in total; last window (11,11); frame_done exactly once; in_ready=0 after pixel 196.
2. Same stream, but win_ready low for 5 cycles at window (3,4) -> in_ready=0 and buf_en=0 for those 5 cycles; win_row=3 and win_col=4 held; no pixel lost; total still 144 windows.
3. in_valid toggled randomly at 50% -> buf_en asserted only on accept cycles; window sequence identical to test 1.
4. Pixels (r,0) and (r,1) for r>=2 -> no win_valid on the following cycle; col wraps 13->0 with row incrementing.
5. abort asserted after pixel 100 -> IDLE next edge with win_valid=0 and no frame_done; a new start plus 196 pixels gives 144 correct windows.
6. start pulsed during RUN, and rst_n pulsed low mid-frame -> start ignored; after reset all outputs are 0 and the controller idles until the next start.

Source files
------------

// File: rtl/conv2_window_ctrl.sv
// Window sequencer for the conv-2 sliding-window line buffer.
// Counts raster pixels, drives the buffer shift-enable, flags legal 3x3 windows.
module conv2_window_ctrl #(
    parameter int FEATURE_MAP_SIZE = 14,
    parameter int KERNEL_SIZE      = 3,
    parameter int CNT_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FEATURE_MAP_SIZE - 1);
    localparam logic [CNT_W-1:0] KM1  = CNT_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             win_hit;
    logic             last_pix;

    // A held window blocks the shift so taps and coordinates stay stable.
    assign in_ready = (state == RUN) && (!win_valid || win_ready);
    assign buf_en   = in_valid && in_ready;
    assign win_hit  = buf_en && (row >= KM1) && (col >= KM1);
    assign last_pix = buf_en && (row == LAST) && (col == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (win_hit) begin
                win_valid <= 1'b1;
                win_row   <= row - KM1;
                win_col   <= col - KM1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_pix) begin
                        state <= DRAIN;
                        row   <= '0;
                        col   <= '0;
                    end else if (buf_en) begin
                        if (col == LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_window_ctrl.sv
// Randomized bench for conv2_window_ctrl against a raster-index window model.
// Windows are predicted from pixel index p as (p/14-2, p%14-2).
module tb_conv2_window_ctrl;

    localparam int N  = 14;
    localparam int K  = 3;
    localparam int NW = (N - K + 1) * (N - K + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic       buf_en;
    logic       win_valid;
    logic       win_ready;
    logic [3:0] win_row;
    logic [3:0] win_col;
    logic       busy;
    logic       frame_done;

    conv2_window_ctrl #(
        .FEATURE_MAP_SIZE(N),
        .KERNEL_SIZE(K),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .buf_en(buf_en),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_row(win_row),
        .win_col(win_col),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state of the current cycle.
    int p;
    bit running;
    bit draining;
    bit exp_wv;
    bit exp_fd;
    int exp_wr;
    int exp_wc;
    int nwin;
    int nfd;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        running  = 0;
        draining = 0;
        exp_wv   = 0;
        exp_fd   = 0;
    endtask

    task automatic step();
        bit acc;
        bit fd_n;
        int r;
        int c;
        #1;
        chk("win_valid", win_valid, exp_wv);
        if (exp_wv) begin
            chk("win_row", win_row, exp_wr);
            chk("win_col", win_col, exp_wc);
        end
        chk("buf_en", buf_en, in_valid & in_ready);
        chk("in_ready", in_ready, running && (!exp_wv || win_ready));
        chk("busy", busy, running || draining);
        chk("frame_done", frame_done, exp_fd);
        if (win_valid && win_ready) nwin++;
        if (frame_done) nfd++;
        if (abort) begin
            model_reset();
        end else begin
            acc  = running && in_valid && (!exp_wv || win_ready);
            fd_n = draining && (!exp_wv || win_ready);
            if (!running && !draining && !exp_fd && start) begin
                running = 1;
                p = 0;
            end else if (acc) begin
                r = p / N;
                c = p % N;
                p++;
                if (p == N * N) begin
                    running  = 0;
                    draining = 1;
                end
            end
            if (acc && r >= K - 1 && c >= K - 1) begin
                exp_wv = 1;
                exp_wr = r - (K - 1);
                exp_wc = c - (K - 1);
            end else if (win_ready) begin
                exp_wv = 0;
            end
            if (fd_n) draining = 0;
            exp_fd = fd_n;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            abort     = 1'b0;
            in_valid  = 1'b1;
            win_ready = 1'b1;
            step();
        end
    endtask

    // mode 0: full rate; 1: 5-cycle stall at window (3,4); 2: random.
    task automatic run_frame(int mode, int abort_at, int start_at,
                             int reset_at);
        int  stall = 0;
        int  n = 0;
        bit  seen = 0;
        bit  cut = 0;
        nwin = 0;
        nfd  = 0;
        start     = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b1;
        step();
        while (!seen && !cut && n < 3000) begin
            n++;
            start     = (n == start_at) || exp_fd;
            abort     = running && (p == abort_at);
            in_valid  = (mode == 2) ? 1'($urandom % 2) : 1'b1;
            win_ready = (mode == 2) ? 1'($urandom % 4 != 0) : 1'b1;
            if (mode == 1 && exp_wv && exp_wr == 3 && exp_wc == 4
                && stall < 5) begin
                win_ready = 1'b0;
                stall++;
            end
            if (running && p == reset_at) begin
                do_reset();
                cut = 1;
            end else begin
                seen = frame_done;
                step();
                if (abort) cut = 1;
            end
        end
        if (!seen && !cut) chk("timeout", 0, 1);
        if (!cut) begin
            chk("windows", nwin, NW);
            chk("pixels", p, N * N);
            chk("frame_done_count", nfd, 1);
            if (mode == 1) chk("stall_cycles", stall, 5);
        end else begin
            chk("no_frame_done", nfd, 0);
        end
        idle_steps(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        p         = 0;
        nwin      = 0;
        nfd       = 0;
        exp_wr    = 0;
        exp_wc    = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        idle_steps(2);

        run_frame(0, -1, -1, -1);
        run_frame(1, -1, -1, -1);
        run_frame(2, -1, -1, -1);
        run_frame(0, 100, -1, -1);
        run_frame(0, -1, -1, -1);
        run_frame(0, -1, 50, 120);
        idle_steps(4);
        run_frame(2, -1, 20, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
